// File: rtl/sram_ctrl_pkg.sv
// Shared sizing constants and types for the 20x64 single-port SRAM controller.
package sram_ctrl_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned WORDS      = 20;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_entry_t;

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// Two-entry in-order read-response FIFO; entry 0 is always the head, so the
// response outputs come straight from flops.
module sram_ctrl_rsp_fifo
    import sram_ctrl_pkg::*;
(
    input  logic       clk0,
    input  logic       rst0,
    input  logic       push,
    input  rsp_entry_t push_data,
    input  logic       rsp_ready,
    output logic       rsp_valid,
    output rsp_entry_t head,
    output logic [1:0] count
);

    rsp_entry_t tail;
    logic       pop;

    assign rsp_valid = (count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= push_data;
                    else               tail <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                // Simultaneous capture and pop: occupancy is unchanged, the
                // new entry lands behind whatever remains.
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_1rw_ctrl_20x64.sv
// Request/response controller for a 20-word x 64-bit 1RW SRAM macro.
// Optional power-up zero fill of the macro: define SRAM_CTRL_INIT_EN.
module sram_1rw_ctrl_20x64 #(
    parameter int unsigned DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
    parameter int unsigned WORDS      = sram_ctrl_pkg::WORDS
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  oob_write,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    import sram_ctrl_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

    state_t     state;
    logic       s1_v, s1_oob, s2_v, s2_oob;
    logic [1:0] fifo_count;
    logic [1:0] credit;
    logic       accept;
    logic       in_range;
    rsp_entry_t push_data;
    rsp_entry_t head;

`ifdef SRAM_CTRL_INIT_EN
    logic [ADDR_WIDTH-1:0] init_cnt;
`endif

    // Credits cover reads still in the macro pipeline plus queued responses,
    // so a capture can never find the FIFO full.
    assign credit    = {1'b0, s1_v} + {1'b0, s2_v} + fifo_count;
    assign req_ready = init_done && (credit < 2'd2);
    assign accept    = req_valid && req_ready;
    assign in_range  = (req_addr <= LAST_ADDR);

    assign push_data = '{rdata: (s2_oob ? '0 : sram_dout0), err: s2_oob};

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
`ifdef SRAM_CTRL_INIT_EN
            state     <= INIT;
            init_done <= 1'b0;
            init_cnt  <= '0;
`else
            state     <= RUN;
            init_done <= 1'b1;
`endif
            sram_csb0  <= 1'b1;
            sram_web0  <= 1'b1;
            sram_addr0 <= '0;
            sram_din0  <= '0;
            oob_write  <= 1'b0;
            s1_v       <= 1'b0;
            s1_oob     <= 1'b0;
            s2_v       <= 1'b0;
            s2_oob     <= 1'b0;
        end else begin
            sram_csb0 <= 1'b1;
            sram_web0 <= 1'b1;
            oob_write <= 1'b0;
            s1_v      <= 1'b0;
            s1_oob    <= 1'b0;
            s2_v      <= s1_v;
            s2_oob    <= s1_oob;
            case (state)
`ifdef SRAM_CTRL_INIT_EN
                INIT: begin
                    sram_csb0  <= 1'b0;
                    sram_web0  <= 1'b0;
                    sram_addr0 <= init_cnt;
                    sram_din0  <= '0;
                    init_cnt   <= init_cnt + 1'b1;
                    if (init_cnt == LAST_ADDR) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
`endif
                RUN: begin
                    if (accept) begin
                        if (req_we) begin
                            if (in_range) begin
                                sram_csb0  <= 1'b0;
                                sram_web0  <= 1'b0;
                                sram_addr0 <= req_addr;
                                sram_din0  <= req_wdata;
                            end else begin
                                oob_write <= 1'b1;
                            end
                        end else begin
                            // Out-of-range reads keep the macro idle but still
                            // take the normal two-cycle slot to stay in order.
                            s1_v   <= 1'b1;
                            s1_oob <= !in_range;
                            if (in_range) begin
                                sram_csb0  <= 1'b0;
                                sram_addr0 <= req_addr;
                            end
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sram_ctrl_rsp_fifo u_rsp_fifo (
        .clk0      (clk0),
        .rst0      (rst0),
        .push      (s2_v),
        .push_data (push_data),
        .rsp_ready (rsp_ready),
        .rsp_valid (rsp_valid),
        .head      (head),
        .count     (fifo_count)
    );

    assign rsp_rdata = head.rdata;
    assign rsp_err   = head.err;

endmodule

// File: tb/tb_sram_1rw_ctrl_20x64.sv
// Directed bench for sram_1rw_ctrl_20x64 with a behavioural 1RW macro model.
// Build with +define+SRAM_CTRL_INIT_EN to cover the zero-fill sequence.
module tb_sram_1rw_ctrl_20x64;

    logic        clk0 = 1'b0;
    logic        rst0 = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        oob_write;
    logic        init_done;
    logic        sram_csb0;
    logic        sram_web0;
    logic [4:0]  sram_addr0;
    logic [63:0] sram_din0;
    logic [63:0] sram_dout0;

    int checks = 0;
    int errors = 0;

`ifdef SRAM_CTRL_INIT_EN
    localparam logic RST_INIT_DONE = 1'b0;
`else
    localparam logic RST_INIT_DONE = 1'b1;
`endif

    always #5 clk0 = ~clk0;

    sram_1rw_ctrl_20x64 #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .WORDS(20)) dut (
        .clk0       (clk0),
        .rst0       (rst0),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .oob_write  (oob_write),
        .init_done  (init_done),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
    );

    // Macro model: one-cycle synchronous read, write on select with web0 low.
    logic [63:0] mem [0:31];
    always @(posedge clk0) begin
        if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] <= sram_din0;
            else            sram_dout0 <= mem[sram_addr0];
        end
    end

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [63:0] wdata;
        logic        exp_csb;
        logic        exp_web;
        logic        exp_oob;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mkv(input logic we, input logic [4:0] addr, input logic [63:0] wdata,
                                 input logic csb, input logic web, input logic oob,
                                 input logic [63:0] rdata, input logic err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata;
        v.exp_csb = csb; v.exp_web = web; v.exp_oob = oob;
        v.exp_rdata = rdata; v.exp_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int unsigned w;
        w = 0;
        while (!req_ready && w < 60) begin
            tick();
            w++;
        end
        if (!req_ready) chk({tag, "_ready_timeout"}, 64'(req_ready), 64'd1);
    endtask

    // One isolated request with rsp_ready high; checks the macro pins after
    // the accept edge and the response slot two edges later.
    task automatic do_vec(input vec_t v, input string tag);
        wait_ready(tag);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        tick();
        req_valid = 1'b0;
        chk({tag, "_csb"}, 64'(sram_csb0), 64'(v.exp_csb));
        chk({tag, "_web"}, 64'(sram_web0), 64'(v.exp_web));
        chk({tag, "_oob"}, 64'(oob_write), 64'(v.exp_oob));
        if (!v.exp_csb) chk({tag, "_addr"}, 64'(sram_addr0), 64'(v.addr));
        if (!v.exp_csb && v.we) chk({tag, "_din"}, sram_din0, v.wdata);
        tick();
        chk({tag, "_oob_clear"}, 64'(oob_write), 64'd0);
        chk({tag, "_csb_idle"}, 64'(sram_csb0), 64'd1);
        chk({tag, "_rsp_early"}, 64'(rsp_valid), 64'd0);
        tick();
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(!v.we));
        if (!v.we) begin
            chk({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
            chk({tag, "_err"}, 64'(rsp_err), 64'(v.exp_err));
        end
        tick();
        chk({tag, "_rsp_drained"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp_q [$];
        logic [63:0] got [$];
        logic [63:0] last_w;
        logic        acc;
        int          op;
        int          n_rd;

        vecs[0]  = mkv(1'b1, 5'd5,  64'hDEADBEEF_00000005, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        vecs[1]  = mkv(1'b0, 5'd5,  64'd0,                 1'b0, 1'b1, 1'b0, 64'hDEADBEEF_00000005, 1'b0);
        vecs[2]  = mkv(1'b1, 5'd0,  64'h11112222_33334444, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        vecs[3]  = mkv(1'b1, 5'd19, 64'h01234567_89ABCDEF, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        vecs[4]  = mkv(1'b0, 5'd19, 64'd0,                 1'b0, 1'b1, 1'b0, 64'h01234567_89ABCDEF, 1'b0);
        vecs[5]  = mkv(1'b0, 5'd0,  64'd0,                 1'b0, 1'b1, 1'b0, 64'h11112222_33334444, 1'b0);
        vecs[6]  = mkv(1'b0, 5'd25, 64'd0,                 1'b1, 1'b1, 1'b0, 64'd0, 1'b1);
        vecs[7]  = mkv(1'b1, 5'd31, 64'hFFFF0000_FFFF0000, 1'b1, 1'b1, 1'b1, 64'd0, 1'b0);
        vecs[8]  = mkv(1'b1, 5'd20, 64'h5555AAAA_5555AAAA, 1'b1, 1'b1, 1'b1, 64'd0, 1'b0);
        vecs[9]  = mkv(1'b0, 5'd20, 64'd0,                 1'b1, 1'b1, 1'b0, 64'd0, 1'b1);
        vecs[10] = mkv(1'b0, 5'd5,  64'd0,                 1'b0, 1'b1, 1'b0, 64'hDEADBEEF_00000005, 1'b0);

        // Reset values
        #12;
        chk("rst_csb", 64'(sram_csb0), 64'd1);
        chk("rst_web", 64'(sram_web0), 64'd1);
        chk("rst_addr", 64'(sram_addr0), 64'd0);
        chk("rst_din", sram_din0, 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rdata", rsp_rdata, 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        chk("rst_oob", 64'(oob_write), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'(RST_INIT_DONE));
        chk("rst_ready", 64'(req_ready), 64'(RST_INIT_DONE));
        tick();
        rst0 = 1'b0;

`ifdef SRAM_CTRL_INIT_EN
        for (int n = 1; n <= 20; n++) begin
            tick();
            chk($sformatf("init%0d_csb", n), 64'(sram_csb0), 64'd0);
            chk($sformatf("init%0d_web", n), 64'(sram_web0), 64'd0);
            chk($sformatf("init%0d_addr", n), 64'(sram_addr0), 64'(n - 1));
            chk($sformatf("init%0d_din", n), sram_din0, 64'd0);
            chk($sformatf("init%0d_done", n), 64'(init_done), 64'(n == 20));
        end
        do_vec(mkv(1'b0, 5'd19, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0), "init_rd19");
`endif

        for (int i = 0; i < 11; i++) do_vec(vecs[i], $sformatf("vec%0d", i));

        // Three reads with responses blocked: the third must stall.
        rsp_ready = 1'b0;
        wait_ready("stall");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd0;
        tick();
        req_addr = 5'd5;
        tick();
        req_addr = 5'd19;
        chk("stall_ready0", 64'(req_ready), 64'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("stall_ready%0d", c + 1), 64'(req_ready), 64'd0);
        end
        chk("stall_head_valid", 64'(rsp_valid), 64'd1);
        chk("stall_head_data", rsp_rdata, 64'h11112222_33334444);
        rsp_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 30 && got.size() < 3; c++) begin
            if (rsp_valid) got.push_back(rsp_rdata);
            acc = req_valid && req_ready;
            tick();
            if (acc) req_valid = 1'b0;
        end
        chk("stall_third_accepted", 64'(req_valid), 64'd0);
        chk("stall_rsp_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("stall_rsp0", got[0], 64'h11112222_33334444);
            chk("stall_rsp1", got[1], 64'hDEADBEEF_00000005);
            chk("stall_rsp2", got[2], 64'h01234567_89ABCDEF);
        end
        req_valid = 1'b0;
        tick();

        // Alternating write/read to addr 0, advancing whenever accepted.
        rsp_ready = 1'b1;
        op = 0; n_rd = 0; last_w = '0;
        exp_q.delete();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd0;
        req_wdata = 64'hC0DE0000_00000000;
        for (int c = 0; c < 400 && n_rd < 20; c++) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("alt_unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    chk($sformatf("alt_rd%0d", n_rd), rsp_rdata, exp_q.pop_front());
                    chk($sformatf("alt_err%0d", n_rd), 64'(rsp_err), 64'd0);
                end
                n_rd++;
            end
            acc = req_valid && req_ready;
            if (acc && req_we) last_w = req_wdata;
            if (acc && !req_we) exp_q.push_back(last_w);
            tick();
            if (acc) begin
                op++;
                if (op < 40) begin
                    req_we    = (op % 2 == 0);
                    req_wdata = 64'hC0DE0000_00000000 | (64'(op) * 64'h0001_0001);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        chk("alt_read_count", 64'(n_rd), 64'd20);
        req_valid = 1'b0;
        tick();

        // Reset with two reads in flight: nothing may come out afterwards.
        wait_ready("flush");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd0;
        tick();
        req_addr = 5'd5;
        tick();
        req_valid = 1'b0;
        rst0 = 1'b1;
        #1;
        chk("flush_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("flush_rst_csb", 64'(sram_csb0), 64'd1);
        chk("flush_rst_ready", 64'(req_ready), 64'(RST_INIT_DONE));
        tick();
        tick();
        rst0 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            chk($sformatf("flush_no_rsp%0d", c), 64'(rsp_valid), 64'd0);
        end
        chk("flush_init_done", 64'(init_done), 64'd1);
        chk("flush_ready", 64'(req_ready), 64'd1);
        do_vec(mkv(1'b1, 5'd7, 64'hA5A5A5A5_0000_0007, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0), "post_wr7");
        do_vec(mkv(1'b0, 5'd7, 64'd0, 1'b0, 1'b1, 1'b0, 64'hA5A5A5A5_0000_0007, 1'b0), "post_rd7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_1rw_ctrl_20x64.md
SRAM_1RW_CTRL_20X64 -- requirements
Module: sram_1rw_ctrl_20x64

Interface
REQ-001 Parameter DATA_WIDTH, 64, word width.
REQ-002 Parameter ADDR_WIDTH, 5, macro address width.
REQ-003 Parameter WORDS, 20, implemented words; addresses >= WORDS are out of range.
REQ-004 The module SHALL have one clock and an asynchronous, active-high reset, ports as below.
REQ-005 clk0  in  1  clock; also the clock of the attached 1RW macro.
REQ-006 rst0  in  1  asynchronous active-high reset.
REQ-007 req_valid/req_ready  in/out  1/1  request handshake; transfer on the clk0 edge where both are 1.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_WIDTH  word address.
REQ-010 req_wdata  in  DATA_WIDTH  write data.
REQ-011 rsp_valid/rsp_ready  out/in  1/1  read-response handshake.
REQ-012 rsp_rdata  out  DATA_WIDTH  read data.
REQ-013 rsp_err  out  1  read targeted an out-of-range address.
REQ-014 oob_write  out  1  one-cycle pulse: out-of-range write dropped.
REQ-015 init_done  out  1  controller accepts requests.
REQ-016 sram_csb0, sram_web0  out  1/1  macro active-low select and write enable.
REQ-017 sram_addr0, sram_din0  out  ADDR_WIDTH/DATA_WIDTH  macro address and write data.
REQ-018 sram_dout0  in  DATA_WIDTH  macro read data.

Function
REQ-019 All macro-side outputs SHALL be driven directly from flops updated on posedge clk0.
REQ-020 Accepted in-range write at edge k: edge k drives csb0=0, web0=0, addr0, din0; no response is generated.
REQ-021 Accepted read at edge k: edge k drives csb0=0, web0=1, addr0; edge k+2 captures sram_dout0 into the response FIFO.
REQ-022 Cycles with no accepted request SHALL drive csb0=1 and web0=1, and hold addr0 and din0.
REQ-023 Out-of-range write: keep csb0=1; pulse oob_write for the cycle after edge k.
REQ-024 Out-of-range read: keep csb0=1; occupy the same 2-cycle slot; enqueue rdata=0, err=1 at edge k+2.
REQ-025 Response FIFO SHALL be 2 entries, in order; rsp_valid = FIFO non-empty; pop on rsp_valid && rsp_ready.
REQ-026 Credit count = reads in flight + FIFO occupancy, range 0..2.
REQ-027 req_ready = init_done && credit < 2; req_ready SHALL NOT depend on req_we or req_valid.
REQ-028 A capture and a pop on the same edge SHALL both take effect; credit changes by net amount.
REQ-029 Back-to-back requests (one per cycle) SHALL be sustained while credits allow.
REQ-030 Read-after-write to the same address on consecutive cycles SHALL return the new data.
REQ-031 States: INIT, RUN; RUN is terminal until reset.

Reset
REQ-032 rst0 asserted: csb0=1, web0=1, addr0=0, din0=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, oob_write=0.
REQ-033 Reset asserted at any time SHALL empty the FIFO, clear credits and discard in-flight reads.
REQ-034 Reset SHALL set state=INIT and init_done=0 (with SRAM_CTRL_INIT_EN), else state=RUN and init_done=1.

Configuration
REQ-035 Macro SRAM_CTRL_INIT_EN defined: INIT writes 0 to addresses 0..WORDS-1, one per cycle.
REQ-036 INIT timing: addr n is driven at edge n+1 after reset release; init_done=1 from edge WORDS.
REQ-037 Macro SRAM_CTRL_INIT_EN undefined: no INIT state; requests are accepted from the first edge after reset release.

Structure
REQ-038 Package sram_ctrl_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH, WORDS, the state enum and the response-entry struct {rdata, err}.
REQ-039 Sub-module sram_ctrl_rsp_fifo SHALL implement the 2-entry response FIFO.

Verification
REQ-040 Write 0xDEADBEEF_00000005 to addr 5, then read addr 5 -> rsp_rdata=0xDEADBEEF_00000005, rsp_err=0, rsp_valid from edge k+2.
REQ-041 rsp_ready=0, issue 3 reads -> third read stalls (req_ready=0); raise rsp_ready -> three responses in order.
REQ-042 Read addr 25 -> csb0 stays 1, rsp_err=1, rsp_rdata=0; write addr 31 -> oob_write pulses for one cycle.
REQ-043 Build with SRAM_CTRL_INIT_EN -> 20 writes of 0 to addrs 0..19, init_done at edge 20; read addr 19 -> 0.
REQ-044 Assert rst0 with 2 reads in flight -> no response ever appears, credit=0, req_ready follows REQ-034.
REQ-045 Alternating write/read to addr 0 every cycle for 40 cycles, rsp_ready=1 -> each read returns the preceding write's data.
